// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex seven-segment scan driver with frame-synchronous shadow update and leading-zero blanking.
// Outputs registered (1-cycle latency); optional anode dimming when SEG7_DIM_EN is defined.
module seg7_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int SLOT_LOG2 = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [3:0]            brightness,
    output logic [DIGITS-1:0]     an_out,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic                  load_pending,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [SLOT_LOG2-1:0] pcnt;
    logic [IDX_W-1:0]     idx;
    logic                 frame_end;

    logic [4*DIGITS-1:0]  staged_digits;
    logic [DIGITS-1:0]    staged_dp;
    logic [4*DIGITS-1:0]  shadow_digits;
    logic [DIGITS-1:0]    shadow_dp;

    logic [DIGITS-1:0]    blank_mask;
    logic [3:0]           cur_nibble;
    logic                 lit;
    logic [DIGITS-1:0]    an_next;
    logic [6:0]           seg_next;
    logic                 dp_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    hex_to_seg = 7'b1000000;
            4'h1:    hex_to_seg = 7'b1111001;
            4'h2:    hex_to_seg = 7'b0100100;
            4'h3:    hex_to_seg = 7'b0110000;
            4'h4:    hex_to_seg = 7'b0011001;
            4'h5:    hex_to_seg = 7'b0010010;
            4'h6:    hex_to_seg = 7'b0000010;
            4'h7:    hex_to_seg = 7'b1111000;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0010000;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b0000011;
            4'hC:    hex_to_seg = 7'b1000110;
            4'hD:    hex_to_seg = 7'b0100001;
            4'hE:    hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    assign frame_end = (&pcnt) && (idx == IDX_W'(DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            idx  <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
            if (&pcnt) begin
                if (idx == IDX_W'(DIGITS - 1))
                    idx <= '0;
                else
                    idx <= idx + 1'b1;
            end
        end
    end

    // A load landing on the boundary cycle is staged for the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staged_digits <= '0;
            staged_dp     <= '0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            load_pending  <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (frame_end && load_pending) begin
                shadow_digits <= staged_digits;
                shadow_dp     <= staged_dp;
            end
            if (load) begin
                staged_digits <= digits_in;
                staged_dp     <= dp_in;
                load_pending  <= 1'b1;
            end else if (frame_end) begin
                load_pending  <= 1'b0;
            end
        end
    end

    always_comb begin : p_blank
        logic upper_zero;
        upper_zero = 1'b1;
        blank_mask = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero    = upper_zero && (shadow_digits[4*k +: 4] == 4'h0);
            blank_mask[k] = blank_lz && (k != 0) && upper_zero;
        end
    end

`ifdef SEG7_DIM_EN
    assign lit = (pcnt[SLOT_LOG2-1 -: 4] <= brightness);
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign lit = 1'b1;
`endif

    assign cur_nibble = shadow_digits[idx*4 +: 4];
    assign an_next    = lit ? ~(DIGITS'(1) << idx) : '1;
    assign seg_next   = blank_mask[idx] ? 7'h7F : hex_to_seg(cur_nibble);
    assign dp_next    = ~shadow_dp[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_out  <= '1;
            seg_out <= 7'h7F;
            dp_out  <= 1'b1;
        end else begin
            an_out  <= an_next;
            seg_out <= seg_next;
            dp_out  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIGITS=4, SLOT_LOG2=4): expected slots queued per frame, checked by a slot monitor.
module tb_seg7_scan_driver;

    localparam int DIGITS    = 4;
    localparam int SLOT_LOG2 = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  brightness = 4'd15;
    logic [3:0]  an_out;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic        load_pending;
    logic        frame_done;

    seg7_scan_driver #(.DIGITS(DIGITS), .SLOT_LOG2(SLOT_LOG2)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .brightness(brightness), .an_out(an_out), .seg_out(seg_out),
        .dp_out(dp_out), .load_pending(load_pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    slot_t      exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         j = 0;
    int         lit = 0;
    logic [3:0] prev_an = 4'hF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_slot(input logic [3:0] an, input logic [6:0] seg, input logic dp);
        slot_t s;
        s.an = an; s.seg = seg; s.dp = dp;
        exp_q.push_back(s);
    endtask

    // Segment codes for digits 3..0 (hand-decoded), dpl = which decimal points are lit.
    task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                              input logic [6:0] s0, input logic [3:0] dpl);
        push_slot(4'b1110, s0, ~dpl[0]);
        push_slot(4'b1101, s1, ~dpl[1]);
        push_slot(4'b1011, s2, ~dpl[2]);
        push_slot(4'b0111, s3, ~dpl[3]);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        j += n;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
        digits_in = d; dp_in = dp; load = 1'b1;
        tick(1);
        load = 1'b0;
        check("pending_after_load", 32'(load_pending), 32'd1);
    endtask

    task automatic wait_frame(output int lit_cnt);
        int n;
        n = 0; lit_cnt = 0;
        do begin
            @(negedge clk);
            n++;
            if (an_out != 4'hF) lit_cnt++;
        end while (!frame_done && n < 200);
        check("frame_period", 32'(n), 32'(64 - j));
        j = 0;
    endtask

    // Slot monitor: each time a new anode lights, the presented digit is checked.
    always @(negedge clk) begin
        if (!rst && an_out != prev_an && $countones(~an_out) == 1) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL slot_unexpected: got an=%b seg=%h dp=%b, expected no slot", an_out, seg_out, dp_out);
            end else begin
                slot_t e;
                e = exp_q.pop_front();
                check("slot", 32'({an_out, seg_out, dp_out}), 32'(e));
            end
        end
        prev_an = an_out;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an_out), 32'hF);
        check("rst_seg", 32'(seg_out), 32'h7F);
        check("rst_dp", 32'(dp_out), 32'd1);
        check("rst_pending", 32'(load_pending), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        // Frame 0: reset shadow shows 0000 at full brightness
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
        rst = 1'b0; j = 0;
        wait_frame(lit);
        check("lit_full", 32'(lit), 32'd64);

        // Frame 1: mid-frame load must not tear the display
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
        tick(20);
        do_load(16'h12AF, 4'b0000);
        tick(63 - j);
        check("pending_hold", 32'(load_pending), 32'd1);
        wait_frame(lit);

        // Frame 2: 12AF, two loads then a load exactly on the boundary cycle
        check("pending_cleared", 32'(load_pending), 32'd0);
        push_frame(7'h79, 7'h24, 7'h08, 7'h0E, 4'b0000);
        tick(10);
        do_load(16'h1111, 4'b0000);
        tick(10);
        do_load(16'h2222, 4'b0000);
        tick(63 - j);
        digits_in = 16'h3333; dp_in = 4'b0000; load = 1'b1;
        tick(1);
        load = 1'b0; j = 0;
        check("boundary_frame_done", 32'(frame_done), 32'd1);
        check("boundary_pending", 32'(load_pending), 32'd1);

        // Frame 3: last mid-frame load wins
        push_frame(7'h24, 7'h24, 7'h24, 7'h24, 4'b0000);
        tick(1);
        check("frame_done_width", 32'(frame_done), 32'd0);
        wait_frame(lit);

        // Frame 4: boundary load applied one frame later
        check("pending_after_3333", 32'(load_pending), 32'd0);
        push_frame(7'h30, 7'h30, 7'h30, 7'h30, 4'b0000);
        do_load(16'h0050, 4'b0000);
        wait_frame(lit);

        // Frame 5: leading-zero blanking of 0050
        blank_lz = 1'b1;
        push_frame(7'h7F, 7'h7F, 7'h12, 7'h40, 4'b0000);
        do_load(16'h0000, 4'b0000);
        wait_frame(lit);

        // Frame 6: all-zero keeps digit 0 lit
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b0000);
        do_load(16'h0007, 4'b0100);
        wait_frame(lit);

        // Frame 7: decimal point survives a blanked digit
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h78, 4'b0100);
        wait_frame(lit);

        // Frame 8: reset mid-frame discards the pending load
        push_slot(4'b1110, 7'h78, 1'b1);
        do_load(16'h8888, 4'hF);
        tick(5);
        #2 rst = 1'b1;
        #1;
        check("midrst_an", 32'(an_out), 32'hF);
        check("midrst_seg", 32'(seg_out), 32'h7F);
        check("midrst_dp", 32'(dp_out), 32'd1);
        check("midrst_pending", 32'(load_pending), 32'd0);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        blank_lz = 1'b0;
`ifdef SEG7_DIM_EN
        brightness = 4'd3;
`endif
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
        rst = 1'b0; j = 0;
        wait_frame(lit);
`ifdef SEG7_DIM_EN
        check("lit_dim3", 32'(lit), 32'd16);
`else
        check("lit_nodim", 32'(lit), 32'd64);
`endif
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed seven-segment scan driver for N hex digits with tear-free frame-synchronous update, per-digit decimal points, leading-zero blanking and optional brightness dimming. Sits between the datapath/debug registers and the board's shared-cathode display pins, replacing ad-hoc anode-rotation logic in top-level wrappers. Performs its own hex-to-segment decoding and slot timing from the system clock; no divided clock is needed.

## Interface
- DIGITS, 4, number of digits scanned (2..8)
- SLOT_LOG2, 16, log2 of clock cycles per digit slot (≥4); slot length = 2**SLOT_LOG2
- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- digits_in  in  4*DIGITS  hex nibbles; nibble k = bits [4k+3:4k], digit 0 rightmost
- dp_in  in  DIGITS  decimal-point request per digit, 1 = lit
- load  in  1  strobe: capture digits_in/dp_in into staging register
- blank_lz  in  1  1 = blank leading zero digits
- brightness  in  4  dimming duty, 0 = 1/16 … 15 = full (used only with SEG7_DIM_EN)
- an_out  out  DIGITS  anode enables, active-low, one-hot-low while lit
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_out  out  1  decimal point, active-low
- load_pending  out  1  staged data not yet applied to display
- frame_done  out  1  one-cycle pulse at every frame boundary

## Operation
- Slot counter pcnt (SLOT_LOG2 bits) increments each cycle; wraps 2**SLOT_LOG2-1 → 0 and advances digit index idx; idx wraps DIGITS-1 → 0.
- Frame boundary: idx = DIGITS-1 and pcnt all-ones.
- load = 1: staging ← {digits_in, dp_in}, load_pending ← 1. Repeated loads overwrite staging; last one wins.
- At frame boundary with load_pending = 1: shadow ← staging (pre-edge value), load_pending ← 0. If load is also high on that cycle, staging takes the new value and load_pending stays 1 (applied next frame).
- Display always reads shadow, never staging or digits_in directly: no mid-frame tearing.
- Decode: standard hex 0–F (A,b,C,d,E,F glyphs); 0 → seg_out 7'b1000000, 8 → 7'b0000000.
- Leading-zero blanking (blank_lz = 1): digit k (k ≥ 1) blanked when shadow nibbles k..DIGITS-1 are all zero; blanked digit drives seg_out = 7'h7F, dp_out still follows dp bit. Digit 0 never blanked.
- frame_done pulses on the cycle after the boundary edge (same edge that updates shadow).

## Timing
- Reset: pcnt=0, idx=0, staging=0, shadow=0, load_pending=0, frame_done=0, an_out all ones, seg_out=7'h7F, dp_out=1.
- Outputs registered; an_out/seg_out/dp_out reflect idx/pcnt of previous cycle (1-cycle latency). First cycle after reset release: an_out[0]=0 showing "0".
- load → load_pending high next cycle; shadow update latency ≤ DIGITS·2**SLOT_LOG2 cycles.
- blank_lz, brightness sampled every cycle (no staging).
- Reset mid-frame: all state returns to reset values immediately; pending load discarded.

## Configuration
- SEG7_DIM_EN defined: anode for current digit active only while pcnt[SLOT_LOG2-1 -: 4] ≤ brightness; otherwise an_out all ones (segments still driven). brightness=15 gives full slot, 0 gives first 1/16.
- Not defined: brightness ignored; current anode active for the entire slot.

## Test plan
- Reset, DIGITS=4, SLOT_LOG2=4: an_out=4'b1111, seg_out=7'h7F during reset; after release an_out sequence 1110,1101,1011,0111 each 16 cycles, seg_out=7'b1000000 throughout.
- load digits_in=16'h12AF mid-frame: display stays 0000 until boundary; frame_done pulse, then digits F,A,2,1 on digits 0..3; load_pending 1→0 at that edge.
- load 16'h1111 then 16'h2222 in same frame, plus load on boundary cycle with 16'h3333: next frame shows 2222, following frame 3333.
- blank_lz=1, shadow=16'h0050: digits 3,2 seg_out=7'h7F, digit 1 shows 5, digit 0 shows 0; shadow=0 → only digit 0 lit.
- dp_in=4'b0100 with blank_lz=1, shadow=16'h0007: dp_out=0 only during digit 2 slot, digit 2 segments blank.
- SEG7_DIM_EN, brightness=3: per 16-cycle slot an_out active 4 cycles then all ones 12 cycles; brightness=15: 16 of 16.
